// File: rtl/pf_pkg.sv
// ============================================================================
// Module : pf_pkg
// Shared widths, fetch-sequencer state encoding and a byte bit-reverse helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pf_pkg;
  localparam int PF_CODE_W = 8;
  localparam int PF_ROW_W  = 3;
  localparam int PF_ADDR_W = PF_CODE_W + PF_ROW_W;

  typedef enum logic [2:0] {
    PF_IDLE = 3'd0,
    PF_REQ  = 3'd1,
    PF_WAIT = 3'd2,
    PF_CAPT = 3'd3,
    PF_FULL = 3'd4
  } pf_state_t;

  function automatic logic [7:0] pf_rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction
endpackage

`default_nettype wire

// File: rtl/pf_plane_shifter.sv
// ============================================================================
// Module : pf_plane_shifter
// Holding buffer plus two 8-bit plane shift registers emitting one pixel per pix_ce.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pf_plane_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_pix_ce,
  input  logic        i_capt,
  input  logic [15:0] i_capt_data,
  input  logic        i_fetch_busy,
  output logic        o_hold_full,
  output logic        o_load,
  output logic [1:0]  o_pix,
  output logic        o_pix_valid,
  output logic        o_underrun
);
  logic [15:0] r_hold;
  logic        r_hold_full;
  logic [7:0]  r_sh0;
  logic [7:0]  r_sh1;
  logic [2:0]  r_count;
  logic [1:0]  r_pix;
  logic        r_pix_valid;
  logic        r_underrun;
  logic        w_need;

  assign w_need      = (r_count == 3'd0);
  assign o_load      = i_pix_ce & w_need & r_hold_full & ~i_flush;
  assign o_hold_full = r_hold_full;
  assign o_pix       = r_pix;
  assign o_pix_valid = r_pix_valid;
  assign o_underrun  = r_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 16'd0;
      r_hold_full <= 1'b0;
      r_sh0       <= 8'd0;
      r_sh1       <= 8'd0;
      r_count     <= 3'd0;
      r_pix       <= 2'd0;
      r_pix_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (i_flush) begin
      r_count     <= 3'd0;
      r_hold_full <= 1'b0;
      r_pix       <= 2'd0;
      r_pix_valid <= 1'b0;
    end else begin
      // hold_full is sampled pre-edge, so a capture never feeds a load on the same clk
      if (i_capt) begin
        r_hold      <= i_capt_data;
        r_hold_full <= 1'b1;
      end else if (o_load) begin
        r_hold_full <= 1'b0;
      end
      if (i_pix_ce) begin
        if (w_need) begin
          if (r_hold_full) begin
            r_sh1       <= r_hold[15:8];
            r_sh0       <= r_hold[7:0];
            r_pix       <= {r_hold[15], r_hold[7]};
            r_pix_valid <= 1'b1;
            r_count     <= 3'd7;
          end else begin
            r_pix       <= 2'd0;
            r_pix_valid <= 1'b0;
            if (!i_fetch_busy) r_underrun <= 1'b1;
          end
        end else begin
          r_sh1   <= {r_sh1[6:0], 1'b0};
          r_sh0   <= {r_sh0[6:0], 1'b0};
          r_pix   <= {r_sh1[6], r_sh0[6]};
          r_count <= r_count - 3'd1;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/pf_tile_fetcher.sv
// ============================================================================
// Module : pf_tile_fetcher
// Fetches tile row bytes from both plane ROMs and streams 2-bit pixels to the mixer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pf_tile_fetcher
  import pf_pkg::*;
#(
  parameter int CODE_W = PF_CODE_W,
  parameter int ROW_W  = PF_ROW_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_ce,
  input  logic                    line_start,
  input  logic [ROW_W-1:0]        row,
  output logic                    code_req,
  input  logic                    code_valid,
  input  logic [CODE_W-1:0]       code,
  input  logic                    code_flipx,
  output logic [CODE_W+ROW_W-1:0] rom_a,
  input  logic [7:0]              rom0_d,
  input  logic [7:0]              rom1_d,
  output logic [1:0]              pix,
  output logic                    pix_valid,
  output logic                    underrun
);
  localparam int ADDR_W = CODE_W + ROW_W;

  pf_state_t         r_state;
  logic              r_code_req;
  logic [ADDR_W-1:0] r_rom_a;
  logic [ROW_W-1:0]  r_row_q;
  logic              r_flipx;

  logic              w_load;
  logic              w_hold_full;
  logic              w_capt;
  logic              w_fetch_busy;
  logic [15:0]       w_capt_data;

  assign code_req     = r_code_req;
  assign rom_a        = r_rom_a;
  assign w_capt       = (r_state == PF_CAPT);
  assign w_fetch_busy = (r_state == PF_WAIT) || (r_state == PF_CAPT);
  // Flip is applied at capture so the shifter always emits MSB first
  assign w_capt_data  = r_flipx ? {pf_rev8(rom1_d), pf_rev8(rom0_d)} : {rom1_d, rom0_d};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= PF_IDLE;
      r_code_req <= 1'b0;
      r_rom_a    <= '0;
      r_row_q    <= '0;
      r_flipx    <= 1'b0;
    end else if (line_start) begin
      r_row_q    <= row;
      r_state    <= PF_REQ;
      r_code_req <= 1'b1;
    end else begin
      case (r_state)
        PF_IDLE: r_code_req <= 1'b0;
        PF_REQ: begin
          if (r_code_req && code_valid) begin
            r_rom_a    <= {code, r_row_q};
            r_flipx    <= code_flipx;
            r_state    <= PF_WAIT;
            r_code_req <= 1'b0;
          end
        end
        PF_WAIT: r_state <= PF_CAPT;
        PF_CAPT: r_state <= PF_FULL;
        PF_FULL: begin
          if (w_load || !w_hold_full) begin
            r_state    <= PF_REQ;
            r_code_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= PF_IDLE;
          r_code_req <= 1'b0;
        end
      endcase
    end
  end

  pf_plane_shifter u_shifter (
    .clk          (clk),
    .rst_n        (reset),
    .i_flush      (line_start),
    .i_pix_ce     (pix_ce),
    .i_capt       (w_capt),
    .i_capt_data  (w_capt_data),
    .i_fetch_busy (w_fetch_busy),
    .o_hold_full  (w_hold_full),
    .o_load       (w_load),
    .o_pix        (pix),
    .o_pix_valid  (pix_valid),
    .o_underrun   (underrun)
  );
endmodule

`default_nettype wire

// File: tb/tb_pf_tile_fetcher.sv
// ============================================================================
// Module : tb_pf_tile_fetcher
// Randomized bench for pf_tile_fetcher against a transaction-level pixel model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pf_tile_fetcher;
  logic        clk;
  logic        reset;
  logic        pix_ce;
  logic        line_start;
  logic [2:0]  row;
  logic        code_req;
  logic        code_valid;
  logic [7:0]  code;
  logic        code_flipx;
  logic [10:0] rom_a;
  logic [7:0]  rom0_d;
  logic [7:0]  rom1_d;
  logic [1:0]  pix;
  logic        pix_valid;
  logic        underrun;

  int n_cmp = 0;
  int n_mis = 0;

  pf_tile_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .row        (row),
    .code_req   (code_req),
    .code_valid (code_valid),
    .code       (code),
    .code_flipx (code_flipx),
    .rom_a      (rom_a),
    .rom0_d     (rom0_d),
    .rom1_d     (rom1_d),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [10:0] a);
    return a[7:0] ^ {5'b0, a[10:8]};
  endfunction

  // Registered-output plane ROMs
  always_ff @(posedge clk) begin
    rom0_d <= rom_f(rom_a);
    rom1_d <= ~rom_f(rom_a);
  end

  // Reference model: fetched tiles as lists of pixels in display order
  bit          m_req, m_hold, m_full, m_pv, m_ur, m_fx;
  int          m_age;            // clks since transfer while a ROM read is in flight, 0 = none
  logic [1:0]  m_pix;
  logic [10:0] m_rom_a;
  logic [2:0]  m_row;
  logic [1:0]  m_holdpix[8];
  logic [1:0]  m_q[$];

  task automatic model_reset();
    m_req = 0; m_hold = 0; m_full = 0; m_pv = 0; m_ur = 0; m_fx = 0;
    m_age = 0; m_pix = 2'd0; m_rom_a = 11'd0; m_row = 3'd0;
    m_q.delete();
  endtask

  task automatic model_step(input bit ls, input bit pce, input bit cv,
                            input logic [7:0] cd, input bit fx, input logic [2:0] rw);
    bit   load, old_req, old_full;
    int   old_age;
    logic [7:0] p0, p1;
    if (ls) begin
      m_q.delete();
      m_hold = 0; m_pv = 0; m_pix = 2'd0; m_row = rw;
      m_req = 1; m_age = 0; m_full = 0;
      return;
    end
    load     = pce && (m_q.size() == 0) && m_hold;
    old_age  = m_age;
    old_req  = m_req;
    old_full = m_full;
    if (pce) begin
      if (m_q.size() == 0) begin
        if (m_hold) begin
          for (int i = 0; i < 8; i++) m_q.push_back(m_holdpix[i]);
          m_pix = m_q.pop_front();
          m_pv = 1;
          m_hold = 0;
        end else begin
          m_pix = 2'd0;
          m_pv = 0;
          if (old_age == 0) m_ur = 1;
        end
      end else begin
        m_pix = m_q.pop_front();
      end
    end
    if (old_age == 1) m_age = 2;
    else if (old_age == 2) begin
      p0 = rom_f(m_rom_a);
      p1 = ~p0;
      for (int i = 0; i < 8; i++)
        m_holdpix[i] = m_fx ? {p1[i], p0[i]} : {p1[7-i], p0[7-i]};
      m_hold = 1; m_age = 0; m_full = 1;
    end
    if (old_req && cv) begin
      m_rom_a = {cd, m_row}; m_fx = fx; m_age = 1; m_req = 0;
    end
    if (old_full && load) begin
      m_full = 0; m_req = 1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("code_req",  {31'd0, code_req},  {31'd0, m_req});
    check_val("rom_a",     {21'd0, rom_a},     {21'd0, m_rom_a});
    check_val("pix",       {30'd0, pix},       {30'd0, m_pix});
    check_val("pix_valid", {31'd0, pix_valid}, {31'd0, m_pv});
    check_val("underrun",  {31'd0, underrun},  {31'd0, m_ur});
  endtask

  task automatic step(input bit ls, input bit pce, input bit cv,
                      input logic [7:0] cd, input bit fx, input logic [2:0] rw);
    line_start = ls; pix_ce = pce; code_valid = cv; code = cd; code_flipx = fx; row = rw;
    @(posedge clk);
    model_step(ls, pce, cv, cd, fx, rw);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 3'd0);
  endtask

  task automatic do_reset();
    line_start = 0; pix_ce = 0; code_valid = 0;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_outputs();
  endtask

  logic [1:0] s2[8];
  logic [1:0] s3[8];
  int         vcnt;
  int         k;
  bit         pprev, ls, pce, cv, fx, xfer;
  logic [7:0] cd;

  initial begin
    reset = 1'b0; line_start = 0; pix_ce = 0; code_valid = 0;
    code = 8'h00; code_flipx = 0; row = 3'd0;
    #2;
    do_reset();
    idle(3);

    // Straight tile: code 0x12, row 5
    step(1, 0, 0, 8'h00, 0, 3'd5);
    step(0, 0, 1, 8'h12, 0, 3'd0);
    check_val("s2_rom_a", {21'd0, rom_a}, 32'h095);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'h00, 0, 3'd0);
      s2[i] = pix;
      check_val("s2_pv", {31'd0, pix_valid}, 32'd1);
      step(0, 0, 0, 8'h00, 0, 3'd0);
    end

    // Same tile flipped
    step(1, 0, 0, 8'h00, 0, 3'd5);
    step(0, 0, 1, 8'h12, 1, 3'd0);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'h00, 0, 3'd0);
      s3[i] = pix;
      step(0, 0, 0, 8'h00, 0, 3'd0);
    end
    for (int i = 0; i < 8; i++) check_val("s3_reverse", {30'd0, s3[i]}, {30'd0, s2[7-i]});

    // Producer starves across the tile boundary, then resumes
    step(0, 0, 1, 8'h33, 0, 3'd0);
    idle(4);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 8'h00, 0, 3'd0);
      step(0, 0, 0, 8'h00, 0, 3'd0);
    end
    check_val("s4_underrun", {31'd0, underrun}, 32'd1);
    check_val("s4_pv", {31'd0, pix_valid}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 2) == 1, 1, 8'h34 + 8'(i), 0, 3'd0);
    end
    check_val("s4_sticky", {31'd0, underrun}, 32'd1);

    // Reset while a tile sits in the holding buffer
    step(1, 0, 0, 8'h00, 0, 3'd2);
    step(0, 0, 1, 8'h55, 0, 3'd0);
    idle(4);
    do_reset();
    idle(3);
    check_val("s1_req_low", {31'd0, code_req}, 32'd0);

    // Back-to-back codes 0x00..0x0F, pixel enable every 2 clks
    step(1, 0, 0, 8'h00, 0, 3'd3);
    k = 0; vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      xfer = m_req;
      step(0, 0, 1, 8'(k), 0, 3'd0);
      if (xfer) k++;
    end
    for (int i = 0; i < 256; i++) begin
      pce = (i % 2) == 0;
      cv = (k < 16);
      xfer = m_req && cv;
      step(0, pce, cv, 8'(k), 0, 3'd0);
      if (xfer) k++;
      if (pce && pix_valid) vcnt++;
    end
    check_val("s5_valid_cnt", vcnt, 32'd128);
    check_val("s5_underrun", {31'd0, underrun}, 32'd0);

    // line_start while a ROM read is in flight
    step(1, 0, 0, 8'h00, 0, 3'd1);
    step(0, 0, 1, 8'h40, 0, 3'd0);
    step(1, 0, 0, 8'h00, 0, 3'd6);
    check_val("s6_req", {31'd0, code_req}, 32'd1);
    step(0, 0, 1, 8'h41, 0, 3'd0);
    check_val("s6_rom_a", {21'd0, rom_a}, {21'd0, 8'h41, 3'd6});
    idle(4);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'h00, 0, 3'd0);
      step(0, 0, 0, 8'h00, 0, 3'd0);
    end

    // Randomized traffic
    pprev = 0;
    cd = 8'($urandom);
    fx = 1'($urandom);
    for (int i = 0; i < 3000; i++) begin
      ls  = ($urandom_range(0, 199) == 0);
      pce = !pprev && !ls && ($urandom_range(0, 2) != 0);
      cv  = ($urandom_range(0, 3) != 0);
      xfer = m_req && cv && !ls;
      step(ls, pce, cv, cd, fx, 3'($urandom));
      pprev = pce;
      if (xfer) begin
        cd = 8'($urandom);
        fx = 1'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

`default_nettype wire
